data_mem_lsu: RTL and testbench

- Load/store initiator sitting between the CPU execute stage and the 32-bit, byte-addressed, big-endian Harvard data RAM.
- The RAM has a combinational read, a synchronous full-word write and no byte enables. This block issues every RAM access.
- It handles sub-word loads with sign or zero extension, and sub-word stores by read-modify-write.
- It checks alignment and range before any RAM access, and returns each result through a valid/ready response handshake.

---
 rtl/data_mem_lsu.sv | 179 +++++++++++++++++
 tb/tb_data_mem_lsu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - load/store initiator for a big-endian word RAM without byte enables
// Sub-word stores are done as read-modify-write; every result returns through a valid/ready response.
module data_mem_lsu #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic        mem_read_en,
    output logic        mem_write_en
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_bad;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    always_comb begin
        req_misaligned = 1'b0;
        if ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0])
            req_misaligned = 1'b1;
        if ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00))
            req_misaligned = 1'b1;
    end

    // The word base can never wrap when 3 is added, so a 32-bit compare is exact.
    assign req_out_of_range = (({req_addr[31:2], 2'b00} + 32'd3) >= MEM_LIMIT);
    assign req_bad          = req_misaligned || req_out_of_range;

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: lane_byte = mem_readdata[31:24];
            2'd1: lane_byte = mem_readdata[23:16];
            2'd2: lane_byte = mem_readdata[15:8];
            2'd3: lane_byte = mem_readdata[7:0];
            default: lane_byte = 8'h00;
        endcase
        lane_half = addr_q[1] ? mem_readdata[15:0] : mem_readdata[31:16];
    end

    always_comb begin
        load_value = 32'h0;
        case (op_q)
            OP_LB:   load_value = {{24{lane_byte[7]}}, lane_byte};
            OP_LH:   load_value = {{16{lane_half[15]}}, lane_half};
            OP_LW:   load_value = mem_readdata;
            OP_LBU:  load_value = {24'h0, lane_byte};
            OP_LHU:  load_value = {16'h0, lane_half};
            default: load_value = 32'h0;
        endcase
    end

    always_comb begin
        merged_word = mem_readdata;
        if (op_q == OP_SB) begin
            case (addr_q[1:0])
                2'd0: merged_word[31:24] = wdata_q[7:0];
                2'd1: merged_word[23:16] = wdata_q[7:0];
                2'd2: merged_word[15:8]  = wdata_q[7:0];
                2'd3: merged_word[7:0]   = wdata_q[7:0];
                default: merged_word = mem_readdata;
            endcase
        end else if (addr_q[1]) begin
            merged_word[15:0] = wdata_q[15:0];
        end else begin
            merged_word[31:16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = S_RESP;
                    end else begin
                        // addr_q drives the RAM address, so it only moves for real accesses.
                        addr_d  = req_addr;
                        state_d = (req_op == OP_SW) ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                if (op_q == OP_SB || op_q == OP_SH) begin
                    wdata_d = merged_word;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = load_value;
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Enables decode straight from the state so an asynchronous reset drops them at once.
    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_read_en   = (state_q == S_READ);
    assign mem_write_en  = (state_q == S_WRITE);
    assign mem_address   = {addr_q[31:2], 2'b00};
    assign mem_writedata = wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu against a byte-array reference model
module tb_data_mem_lsu;

    localparam int MEM_BYTES = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_read_en;
    logic        mem_write_en;

    logic [31:0] ram [0:MEM_BYTES/4-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];

    int checks = 0;
    int errors = 0;

    data_mem_lsu #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en)
    );

    always #5 clk = ~clk;

    assign mem_readdata = ram[mem_address[6:2]];
    always @(posedge clk) begin
        if (mem_write_en)
            ram[mem_address[6:2]] <= mem_writedata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [2:0] op, input logic [31:0] a);
        longint base;
        logic   bad;
        bad  = 1'b0;
        base = (longint'(a) / 4) * 4;
        if ((op == 3'd1 || op == 3'd4 || op == 3'd6) && (a % 2 != 0)) bad = 1'b1;
        if ((op == 3'd2 || op == 3'd7) && (a % 4 != 0)) bad = 1'b1;
        if (base + 3 >= MEM_BYTES) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] ref_word(input int wa);
        return {ref_mem[wa], ref_mem[wa+1], ref_mem[wa+2], ref_mem[wa+3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
        int v;
        case (op)
            3'd0, 3'd3: begin
                v = int'(ref_mem[a]);
                if (op == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd4: begin
                v = int'(ref_mem[a]) * 256 + int'(ref_mem[a+1]);
                if (op == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: return ref_word(a);
        endcase
        return 32'(v);
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input int hold, output logic [31:0] got_rdata);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;
        int          exp_lat, exp_rd, exp_wr;
        int          lat, nrd, nwr, ia;
        logic        seen;
        exp_err   = ref_bad(op, a);
        exp_rdata = 32'h0;
        exp_wdata = 32'h0;
        ia        = int'(a[6:0]);
        if (exp_err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (op <= 3'd4) begin
            exp_rdata = ref_load(op, ia);
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
        end else begin
            if (op == 3'd5) begin
                ref_mem[ia] = wd[7:0];
            end else if (op == 3'd6) begin
                ref_mem[ia]   = wd[15:8];
                ref_mem[ia+1] = wd[7:0];
            end else begin
                ref_mem[ia]   = wd[31:24];
                ref_mem[ia+1] = wd[23:16];
                ref_mem[ia+2] = wd[15:8];
                ref_mem[ia+3] = wd[7:0];
            end
            exp_wdata = ref_word(ia - ia % 4);
            exp_lat = (op == 3'd7) ? 2 : 3;
            exp_rd  = (op == 3'd7) ? 0 : 1;
            exp_wr  = 1;
        end

        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        nrd = 0; nwr = 0; lat = 0; seen = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read_en) begin
                nrd++;
                check_eq("rd_addr", mem_address, a & ~32'd3);
            end
            if (mem_write_en) begin
                nwr++;
                check_eq("wr_addr", mem_address, a & ~32'd3);
                check_eq("wr_data", mem_writedata, exp_wdata);
            end
            if (resp_valid) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check_eq("resp_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("rd_cycles", 32'(nrd), 32'(exp_rd));
        check_eq("wr_cycles", 32'(nwr), 32'(exp_wr));
        check_eq("rdata", resp_rdata, exp_rdata);
        check_eq("err", 32'(resp_err), 32'(exp_err));
        got_rdata = resp_rdata;

        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_rdata", resp_rdata, exp_rdata);
            check_eq("hold_err", 32'(resp_err), 32'(exp_err));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
            check_eq("hold_no_en", 32'({mem_read_en, mem_write_en}), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  op;
        logic [31:0] a;

        for (int i = 0; i < MEM_BYTES / 4; i++) begin
            ram[i] = $urandom;
            ref_mem[4*i]   = ram[i][31:24];
            ref_mem[4*i+1] = ram[i][23:16];
            ref_mem[4*i+2] = ram[i][15:8];
            ref_mem[4*i+3] = ram[i][7:0];
        end
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        #2;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_enables", 32'({mem_read_en, mem_write_en}), 32'd0);
        check_eq("rst_mem_address", mem_address, 32'h0);
        check_eq("rst_mem_writedata", mem_writedata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'd7, 32'h10, 32'h11223344, 0, r);
        run_op(3'd2, 32'h10, 32'h0, 0, r);
        check_eq("tp_lw_sw", r, 32'h11223344);
        run_op(3'd0, 32'h13, 32'h0, 0, r);
        check_eq("tp_lb13", r, 32'h00000044);
        run_op(3'd5, 32'h11, 32'h00000080, 0, r);
        run_op(3'd2, 32'h10, 32'h0, 0, r);
        check_eq("tp_lw_sb", r, 32'h11803344);
        run_op(3'd0, 32'h11, 32'h0, 0, r);
        check_eq("tp_lb11", r, 32'hFFFFFF80);
        run_op(3'd3, 32'h11, 32'h0, 0, r);
        check_eq("tp_lbu11", r, 32'h00000080);
        run_op(3'd6, 32'h12, 32'hABCDBEEF, 0, r);
        run_op(3'd2, 32'h10, 32'h0, 0, r);
        check_eq("tp_lw_sh", r, 32'h1180BEEF);
        run_op(3'd1, 32'h12, 32'h0, 0, r);
        check_eq("tp_lh12", r, 32'hFFFFBEEF);
        run_op(3'd4, 32'h12, 32'h0, 0, r);
        check_eq("tp_lhu12", r, 32'h0000BEEF);
        run_op(3'd1, 32'h11, 32'h0, 0, r);
        run_op(3'd7, 32'h12, 32'hDEADBEEF, 0, r);
        run_op(3'd2, 32'h80, 32'h0, 0, r);
        run_op(3'd2, 32'h7C, 32'h0, 0, r);
        run_op(3'd2, 32'h10, 32'h0, 5, r);
        check_eq("tp_hold_lw", r, 32'h1180BEEF);
        run_op(3'd4, 32'h10, 32'h0, 0, r);
        check_eq("tp_b2b_lhu", r, 32'h00001180);

        // Reset in the read half of a read-modify-write must leave the word untouched.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_addr  = 32'h20;
        req_wdata = 32'h000000A5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_eq("rmw_in_read", 32'(mem_read_en), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rmw_rst_enables", 32'({mem_read_en, mem_write_en}), 32'd0);
        check_eq("rmw_rst_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd2, 32'h20, 32'h0, 0, r);

        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, MEM_BYTES + 7));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            run_op(op, a, $urandom, $urandom_range(0, 2), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
